// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry holding buffer that lets the next word wait while the current one shifts out.
module piso_hold_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full
);

  logic [WIDTH-1:0] data_q;
  logic             full_q;

  // push only happens while empty and pop only while full, so they never coincide
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (push) begin
      data_q <= push_data;
      full_q <= 1'b1;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

  assign hold_data = data_q;
  assign hold_full = full_q;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with load/ready handshake and a one-word holding register.
module piso_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] datain,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  logic             accept;
  logic             final_bit;
  logic             push;
  logic             pop;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;

  piso_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(datain),
    .pop      (pop),
    .hold_data(hold_data),
    .hold_full(hold_full)
  );

  assign ready = !hold_full;
  assign busy  = (state_q == ST_SHIFT) || hold_full;

  always_comb begin
    accept    = load && ready && !reset;
    final_bit = (state_q == ST_SHIFT) && (cnt_q == LastCnt);
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    pop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = datain;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (final_bit) begin
          cnt_d = '0;
          // Held word wins over a same-edge load so word order is preserved
          if (hold_full) begin
            shreg_d = hold_data;
            pop     = 1'b1;
          end else if (accept) begin
            shreg_d = datain;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          cnt_d   = cnt_q + 1'b1;
          push    = accept;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Output registers look ahead at the next shifter contents so sout is a true flop
    valid_d = (state_d == ST_SHIFT);
    sout_d  = valid_d && (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]);
    last_d  = valid_d && (cnt_d == LastCnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = valid_q;
  assign last       = last_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: an MSB-first and an LSB-first instance driven by the same stimulus.
module tb_piso_tx;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] datain;
  logic       ready_m, sout_m, valid_m, last_m, busy_m;
  logic       ready_l, sout_l, valid_l, last_l, busy_l;

  int tests;
  int fails;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [3:0] din;
    logic       rdy;
    logic       so_m;
    logic       so_l;
    logic       v;
    logic       l;
    logic       b;
  } vec_t;

  vec_t vecs[$];

  piso_tx #(
    .WIDTH    (4),
    .MSB_FIRST(1'b1)
  ) u_msb (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .datain    (datain),
    .ready     (ready_m),
    .sout      (sout_m),
    .sout_valid(valid_m),
    .last      (last_m),
    .busy      (busy_m)
  );

  piso_tx #(
    .WIDTH    (4),
    .MSB_FIRST(1'b0)
  ) u_lsb (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .datain    (datain),
    .ready     (ready_l),
    .sout      (sout_l),
    .sout_valid(valid_l),
    .last      (last_l),
    .busy      (busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Inputs for one edge, then the outputs expected in the cycle after that edge
  task automatic add(input logic rst, input logic ld, input logic [3:0] din, input logic rdy,
                     input logic so_m, input logic so_l, input logic v, input logic l,
                     input logic b);
    vec_t t;
    t.rst = rst; t.ld = ld; t.din = din; t.rdy = rdy;
    t.so_m = so_m; t.so_l = so_l; t.v = v; t.l = l; t.b = b;
    vecs.push_back(t);
  endtask

  logic [7:0] bits_m, bits_l;
  int         nbits;

  initial begin
    tests  = 0;
    fails  = 0;
    reset  = 1'b1;
    load   = 1'b0;
    datain = 4'h0;

    //   rst ld  din   rdy so_m so_l v  l  b
    add(1, 0, 4'h0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 4'hF, 1, 0, 0, 0, 0, 0);  // load ignored in reset
    // single word 1011
    add(0, 1, 4'hB, 1, 1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1, 0, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1, 1, 0, 1, 0, 1);
    add(0, 0, 4'h0, 1, 1, 1, 1, 1, 1);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
    // back-to-back A then 5 through the holding register
    add(0, 1, 4'hA, 1, 1, 0, 1, 0, 1);
    add(0, 1, 4'h5, 0, 0, 1, 1, 0, 1);
    add(0, 0, 4'h0, 0, 1, 0, 1, 0, 1);
    add(0, 0, 4'h0, 0, 0, 1, 1, 1, 1);
    add(0, 0, 4'h0, 1, 0, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1, 1, 0, 1, 0, 1);
    add(0, 0, 4'h0, 1, 0, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1, 1, 0, 1, 1, 1);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
    // C then 3 bypassed on the final edge
    add(0, 1, 4'hC, 1, 1, 0, 1, 0, 1);
    add(0, 0, 4'h0, 1, 1, 0, 1, 0, 1);
    add(0, 0, 4'h0, 1, 0, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1, 0, 1, 1, 1, 1);
    add(0, 1, 4'h3, 1, 0, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1, 0, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1, 1, 0, 1, 0, 1);
    add(0, 0, 4'h0, 1, 1, 0, 1, 1, 1);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
    // reset mid-word with the holding register full, then a clean word 6
    add(0, 1, 4'h9, 1, 1, 1, 1, 0, 1);
    add(0, 1, 4'h6, 0, 0, 0, 1, 0, 1);
    add(1, 1, 4'hF, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 4'h6, 1, 0, 0, 1, 0, 1);
    add(0, 0, 4'h0, 1, 1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1, 1, 1, 1, 0, 1);
    add(0, 0, 4'h0, 1, 0, 0, 1, 1, 1);
    add(0, 0, 4'h0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset  = vecs[i].rst;
      load   = vecs[i].ld;
      datain = vecs[i].din;
      @(posedge clk);
      #1;
      check("ready",  i, {15'd0, ready_m}, {15'd0, vecs[i].rdy});
      check("sout_m", i, {15'd0, sout_m},  {15'd0, vecs[i].so_m});
      check("sout_l", i, {15'd0, sout_l},  {15'd0, vecs[i].so_l});
      check("valid",  i, {14'd0, valid_l, valid_m}, {14'd0, vecs[i].v, vecs[i].v});
      check("last",   i, {14'd0, last_l, last_m},   {14'd0, vecs[i].l, vecs[i].l});
      check("busy",   i, {14'd0, busy_l, busy_m},   {14'd0, vecs[i].b, vecs[i].b});
    end

    // Load held high with changing data while the holding register is full:
    // only 8 and E may be accepted.
    bits_m = '0;
    bits_l = '0;
    nbits  = 0;
    for (int s = 0; s < 14; s++) begin
      reset = 1'b0;
      if (s == 0) begin
        load = 1'b1; datain = 4'h8;
      end else if (s == 1) begin
        load = 1'b1; datain = 4'hE;
      end else if (ready_m) begin
        load = 1'b0; datain = 4'h0;
      end else begin
        load = 1'b1; datain = 4'(s);
      end
      @(posedge clk);
      #1;
      if (valid_m) begin
        if (nbits < 8) begin
          bits_m = {bits_m[6:0], sout_m};
          bits_l = {bits_l[6:0], sout_l};
        end
        nbits++;
      end
    end
    check("hold_nbits", 0, 16'(nbits), 16'd8);
    check("hold_bits_m", 0, {8'd0, bits_m}, 16'h008E);
    check("hold_bits_l", 0, {8'd0, bits_l}, 16'h0017);
    check("hold_idle", 0, {13'd0, valid_m, busy_m, ready_m}, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
